// File: rtl/memory_core.sv
// memory_core: 16-bit line-buffer (delay line) tile built on four SRAM banks.
// Every accepted sample goes into a circular buffer. The sample written
// `depth` writes earlier is emitted one cycle later with a valid strobe.
// A config port loads the CFG register and gives word access to the banks.
// BANK_WORDS must be a power of two between 2 and 256, because the config
// word offset comes from the 8-bit field config_addr[31:24].
module memory_core #(
   parameter int BANK_WORDS = 256
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        clk_en,
   input  logic        config_en,
   input  logic [3:0]  config_en_sram,
   input  logic        config_read,
   input  logic        config_write,
   input  logic [31:0] config_addr,
   input  logic [31:0] config_data,
   output logic [31:0] read_data,
   input  logic [15:0] data_in,
   input  logic        wen_in,
   input  logic        ren_in,
   input  logic [15:0] chain_in,
   input  logic        flush,
   output logic [15:0] data_out,
   output logic        valid_out
);

   localparam int OFF_W = $clog2(BANK_WORDS);
   localparam int PTR_W = OFF_W + 2;
   localparam int CNT_W = OFF_W + 3;
   localparam int CAP   = 4 * BANK_WORDS;

   logic [15:0]      r_cfg;
   logic [PTR_W-1:0] r_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic [15:0]      r_data_out;
   logic             r_valid_out;
   logic [31:0]      r_read_data;

   logic [CNT_W-1:0] w_depth;
   logic             w_active;
   logic             w_full;
   logic             w_ptr_wrap;
   logic             w_dp_wr;
   logic [1:0]       w_dp_bank;
   logic [OFF_W-1:0] w_dp_off;
   logic [OFF_W-1:0] w_cfg_off;
   logic             w_cfg_index_zero;
   logic [15:0]      w_dp_word  [4];
   logic [15:0]      w_cfg_word [4];
   logic [15:0]      w_old_word;
   logic [15:0]      w_sram_word;
   logic             w_sram_hit;
   logic             w_unused;

   // Ports that have no meaning in line-buffer mode
   assign w_unused = ^{ren_in, chain_in, config_addr[23:0], config_data[31:16]};

   // Effective depth: the programmed depth, clamped to the total capacity
   always_comb begin
      if (32'(r_cfg[15:3]) > CAP) w_depth = CNT_W'(CAP);
      else                        w_depth = CNT_W'(r_cfg[15:3]);
   end

   assign w_active   = r_cfg[2] && (r_cfg[1:0] == 2'd0) && (w_depth != '0);
   assign w_full     = (r_cnt >= w_depth);
   // ">=" rather than "==" keeps the pointer in range if depth shrinks
   assign w_ptr_wrap = ({1'b0, r_ptr} >= (w_depth - CNT_W'(1)));
   assign w_dp_wr    = clk_en && !flush && wen_in && w_active;
   assign w_dp_bank  = r_ptr[PTR_W-1 -: 2];
   assign w_dp_off   = r_ptr[OFF_W-1:0];
   assign w_cfg_off  = config_addr[24 +: OFF_W];
   assign w_cfg_index_zero = (config_addr[31:24] == 8'd0);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_bank
         logic [15:0] r_mem [BANK_WORDS];

         // Bank write port: a config write beats a datapath write to the same bank
         always_ff @(posedge clk_in) begin
            if (config_write && config_en_sram[gi])
               r_mem[w_cfg_off] <= config_data[15:0];
            else if (w_dp_wr && (w_dp_bank == 2'(gi)))
               r_mem[w_dp_off] <= data_in;
         end

         assign w_dp_word[gi]  = r_mem[w_dp_off];
         assign w_cfg_word[gi] = r_mem[w_cfg_off];
      end
   endgenerate

   // The old word at the write pointer; it is read before this edge's write
   assign w_old_word = w_dp_word[w_dp_bank];

   // Config SRAM read selects the lowest-numbered enabled bank
   always_comb begin
      w_sram_word = '0;
      w_sram_hit  = 1'b0;
      for (int b = 3; b >= 0; b--) begin
         if (config_en_sram[b]) begin
            w_sram_word = w_cfg_word[b];
            w_sram_hit  = 1'b1;
         end
      end
   end

   // Line-buffer pointer, fill count and delayed output
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         r_ptr       <= '0;
         r_cnt       <= '0;
         r_data_out  <= '0;
         r_valid_out <= 1'b0;
      end else if (clk_en) begin
         if (flush) begin
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_valid_out <= 1'b0;
         end else if (w_dp_wr) begin
            r_ptr       <= w_ptr_wrap ? '0 : r_ptr + PTR_W'(1);
            if (!w_full) r_cnt <= r_cnt + CNT_W'(1);
            r_valid_out <= w_full;
            if (w_full) r_data_out <= w_old_word;
         end else begin
            r_valid_out <= 1'b0;
         end
      end
   end

   // CFG load and registered config readback, both independent of clk_en
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         r_cfg       <= '0;
         r_read_data <= '0;
      end else begin
         if (config_en && w_cfg_index_zero)
            r_cfg <= config_data[15:0];
         if (config_read) begin
            if (config_en && w_cfg_index_zero)
               r_read_data <= {16'b0, r_cfg};
            else if (w_sram_hit)
               r_read_data <= {16'b0, w_sram_word};
         end
      end
   end

   assign data_out  = r_data_out;
   assign valid_out = r_valid_out;
   assign read_data = r_read_data;

endmodule

// File: tb/tb_memory_core.sv
// Self-checking bench for memory_core. The reference model is a FIFO of
// accepted samples: once it holds more than `depth` entries, the oldest one
// is the next expected output. A flat array follows the linear buffer
// contents so that debug readback can be predicted.
module tb_memory_core;

   logic        clk_in = 1'b0;
   logic        reset;
   logic        clk_en;
   logic        config_en;
   logic [3:0]  config_en_sram;
   logic        config_read;
   logic        config_write;
   logic [31:0] config_addr;
   logic [31:0] config_data;
   logic [31:0] read_data;
   logic [15:0] data_in;
   logic        wen_in;
   logic        ren_in;
   logic [15:0] chain_in;
   logic        flush;
   logic [15:0] data_out;
   logic        valid_out;

   memory_core #(.BANK_WORDS(256)) dut (
      .clk_in(clk_in), .reset(reset), .clk_en(clk_en),
      .config_en(config_en), .config_en_sram(config_en_sram),
      .config_read(config_read), .config_write(config_write),
      .config_addr(config_addr), .config_data(config_data),
      .read_data(read_data), .data_in(data_in), .wen_in(wen_in),
      .ren_in(ren_in), .chain_in(chain_in), .flush(flush),
      .data_out(data_out), .valid_out(valid_out)
   );

   always #5 clk_in = ~clk_in;

   // Reference model state
   logic [15:0] q [$];
   logic [15:0] mem_model [1024];
   int          m_depth  = 0;
   bit          m_active = 0;
   int          wcount   = 0;
   logic [15:0] exp_data  = '0;
   logic        exp_valid = 1'b0;
   logic [15:0] cur_cfg   = '0;

   int n_checks = 0;
   int n_fail   = 0;
   int next_val = 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: apply datapath inputs, advance the model, then compare
   task automatic cyc(input logic w, input logic [15:0] d, input logic f, input logic ce);
      wen_in   = w;
      data_in  = d;
      flush    = f;
      clk_en   = ce;
      ren_in   = 1'($urandom_range(0, 1));
      chain_in = 16'($urandom);
      if (ce) begin
         if (f) begin
            q.delete();
            wcount    = 0;
            exp_valid = 1'b0;
         end else if (w && m_active && m_depth > 0) begin
            mem_model[wcount % m_depth] = d;
            wcount++;
            q.push_back(d);
            if (q.size() > m_depth) begin
               exp_data  = q.pop_front();
               exp_valid = 1'b1;
            end else begin
               exp_valid = 1'b0;
            end
         end else begin
            exp_valid = 1'b0;
         end
      end
      @(posedge clk_in);
      #1;
      check("valid_out", {31'b0, valid_out}, {31'b0, exp_valid});
      check("data_out", {16'b0, data_out}, {16'b0, exp_data});
      if (valid_out) $display("t=%0t sample out %04h", $time, data_out);
   endtask

   // Load CFG, let it take effect, then flush the line buffer
   task automatic cfg_load(input logic [15:0] v);
      int raw;
      config_en   = 1'b1;
      config_addr = 32'h0;
      config_data = {16'hA5A5, v};
      cyc(1'b0, 16'h0, 1'b0, 1'b1);
      config_en = 1'b0;
      cur_cfg   = v;
      m_active  = v[2] && (v[1:0] == 2'd0);
      raw       = int'(v[15:3]);
      m_depth   = (raw > 1024) ? 1024 : raw;
      $display("t=%0t cfg load %04h (depth %0d active %0d)", $time, v, m_depth, m_active);
      cyc(1'b0, 16'h0, 1'b1, 1'b1);
   endtask

   task automatic cfg_sram_write(input logic [3:0] banks, input logic [7:0] off, input logic [15:0] v);
      config_en_sram = banks;
      config_write   = 1'b1;
      config_addr    = {off, 24'h0};
      config_data    = {16'h1234, v};
      cyc(1'b0, 16'h0, 1'b0, 1'b0);
      config_write   = 1'b0;
      config_en_sram = 4'b0;
      for (int b = 0; b < 4; b++)
         if (banks[b]) mem_model[b * 256 + int'(off)] = v;
      $display("t=%0t sram write banks %b off %0d data %04h", $time, banks, off, v);
   endtask

   task automatic cfg_sram_read(input string tag, input logic [3:0] banks, input logic [7:0] off,
                                input logic [15:0] expv);
      config_en_sram = banks;
      config_read    = 1'b1;
      config_addr    = {off, 24'h0};
      cyc(1'b0, 16'h0, 1'b0, 1'b0);
      config_read    = 1'b0;
      config_en_sram = 4'b0;
      check(tag, read_data, {16'b0, expv});
      $display("t=%0t sram read banks %b off %0d -> %08h", $time, banks, off, read_data);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; clk_en = 1'b0; config_en = 1'b0; config_en_sram = 4'b0;
      config_read = 1'b0; config_write = 1'b0; config_addr = '0; config_data = '0;
      data_in = '0; wen_in = 1'b0; ren_in = 1'b0; chain_in = '0; flush = 1'b0;

      // Reset state
      repeat (2) @(posedge clk_in);
      #1;
      check("reset_valid", {31'b0, valid_out}, 32'd0);
      check("reset_data", {16'b0, data_out}, 32'd0);
      check("reset_read_data", read_data, 32'd0);
      reset = 1'b1;

      // Reset CFG is inert: writes produce nothing
      for (int i = 0; i < 4; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b1);

      // Depth fill, depth 10, back-to-back incrementing writes
      cfg_load(16'((10 << 3) | 4));
      for (int i = 0; i < 25; i++) begin
         cyc(1'b1, 16'(next_val), 1'b0, 1'b1);
         next_val++;
      end

      // Random write enable with incrementing data
      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            cyc(1'b1, 16'(next_val), 1'b0, 1'b1);
            next_val++;
         end else begin
            cyc(1'b0, 16'($urandom), 1'b0, 1'b1);
         end
      end

      // Flush held three cycles while writing
      for (int i = 0; i < 3; i++) cyc(1'b1, 16'($urandom), 1'b1, 1'b1);
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, 16'(next_val), 1'b0, 1'b1);
         next_val++;
      end

      // clk_en low: wen_in and flush are ignored
      for (int i = 0; i < 5; i++)
         cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      for (int i = 0; i < 15; i++) begin
         cyc(1'b1, 16'(next_val), 1'b0, 1'b1);
         next_val++;
      end

      // SRAM debug readback with the datapath frozen
      cfg_sram_read("sram_read_idx7", 4'b0001, 8'd7, mem_model[7]);
      cfg_sram_write(4'b0100, 8'd5, 16'hCAFE);
      cfg_sram_write(4'b0010, 8'd5, 16'hBEEF);
      cfg_sram_read("sram_read_lowest", 4'b0110, 8'd5, 16'hBEEF);
      cfg_sram_read("sram_read_bank2", 4'b0100, 8'd5, 16'hCAFE);
      cfg_sram_write(4'b1001, 8'd32, 16'h5A5A);
      cfg_sram_read("sram_read_bank3", 4'b1000, 8'd32, 16'h5A5A);

      // Register readback of CFG
      config_en = 1'b1; config_read = 1'b1; config_addr = 32'h0;
      config_data = {16'h0, cur_cfg};
      cyc(1'b0, 16'h0, 1'b0, 1'b1);
      config_en = 1'b0; config_read = 1'b0;
      check("cfg_readback", read_data, {16'b0, cur_cfg});

      // Stream continues in order after the debug accesses
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, 16'(next_val), 1'b0, 1'b1);
         next_val++;
      end

      // Depth 1: each write returns the previous one
      cfg_load(16'((1 << 3) | 4));
      for (int i = 0; i < 12; i++) cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'b0, 1'b1);

      // Depth 0: never valid
      cfg_load(16'((0 << 3) | 4));
      for (int i = 0; i < 8; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b1);

      // tile_en clear and reserved mode are inert
      cfg_load(16'((4 << 3) | 0));
      for (int i = 0; i < 8; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b1);
      cfg_load(16'((4 << 3) | 4 | 1));
      for (int i = 0; i < 8; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b1);

      // Depth above capacity clamps to 1024
      cfg_load(16'((2000 << 3) | 4));
      for (int i = 0; i < 1030; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b1);

      // Reset mid-stream clears outputs immediately
      cfg_load(16'((3 << 3) | 4));
      for (int i = 0; i < 6; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b1);
      reset = 1'b0;
      #1;
      check("midreset_valid", {31'b0, valid_out}, 32'd0);
      check("midreset_data", {16'b0, data_out}, 32'd0);
      check("midreset_read_data", read_data, 32'd0);
      @(posedge clk_in);
      #1;
      reset = 1'b1;
      q.delete(); wcount = 0; exp_data = '0; exp_valid = 1'b0;
      m_active = 0; m_depth = 0; cur_cfg = '0;
      for (int i = 0; i < 4; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b1);
      cfg_load(16'((2 << 3) | 4));
      for (int i = 0; i < 8; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/memory_core.md
# memory_core

Configurable 16-bit memory tile used as a line buffer (delay line) in the CGRA fabric. Each write-enabled sample is stored in an internal circular buffer, and the sample written `depth` writes earlier is emitted with a valid strobe. A configuration port loads the mode/depth register and gives direct word access to the four internal SRAM banks for debug readback.

## Interface
- `BANK_WORDS`, default 256: words per SRAM bank. There are 4 banks, so capacity = 4×BANK_WORDS.
- `clk_in` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `clk_en` input 1: datapath clock enable. Low freezes the line-buffer state; the config port stays active.
- `config_en` input 1: config register access strobe.
- `config_en_sram` input 4: one-hot SRAM bank select for config access.
- `config_read` input 1: config read request.
- `config_write` input 1: config SRAM write request.
- `config_addr` input 32: [31:24] is the register index or the SRAM word offset.
- `config_data` input 32: config write data.
- `read_data` output 32: config readback data, registered.
- `data_in` input 16: sample in.
- `wen_in` input 1: sample write enable.
- `ren_in` input 1: unused in line-buffer mode; ignored.
- `chain_in` input 16: tile chaining input; unused; ignored.
- `flush` input 1: synchronous line-buffer clear.
- `data_out` output 16: delayed sample.
- `valid_out` output 1: `data_out` is valid this cycle.

## Operation
- Config register CFG (index 0), all bits reset to 0:
  - [1:0] `mode`: 0 = line buffer. 1–3 are reserved; in these modes the block is inert (`valid_out`=0, `data_out` holds).
  - [2] `tile_en`: 0 means the block is inert.
  - [15:3] `depth`: 13-bit line-buffer delay. Values above 4×BANK_WORDS are clamped to 4×BANK_WORDS.
- CFG load: `config_en`=1 and `config_addr[31:24]`=0 loads CFG[15:0] from `config_data[15:0]`. `config_write` is not required. This does not depend on `clk_en`.
- Storage: linear word index w maps to bank w/BANK_WORDS, offset w%BANK_WORDS.
- Line buffer, active when `tile_en`=1, mode 0, `depth`≥1:
  - State: write pointer `ptr` (0..depth-1) and fill counter `cnt` (0..depth).
  - On a cycle with `clk_en`=1, `wen_in`=1 and `flush`=0:
    - Read the old word mem[ptr], then write `data_in` to mem[ptr] (read-before-write).
    - `ptr` advances, wrapping from depth-1 to 0.
    - `cnt` increments, saturating at `depth`.
  - If `cnt`==`depth` before that write: next cycle `data_out` = old word and `valid_out`=1. Otherwise `valid_out`=0 next cycle.
  - Cycles without a write: `valid_out`=0 next cycle and `data_out` holds.
  - Net effect: the k-th output equals the k-th input written.
  - `depth`=0: nothing is stored and `valid_out` stays 0.
- `flush` (with `clk_en`=1): `ptr`←0, `cnt`←0, `valid_out`←0. Memory contents are untouched. `flush` has priority over `wen_in`.
- `clk_en`=0: `ptr`, `cnt`, `data_out` and `valid_out` hold. `wen_in` and `flush` are ignored.
- Config SRAM access, independent of `clk_en`, at offset a=`config_addr[31:24]` in each bank b whose `config_en_sram[b]`=1:
  - Write (`config_write`=1): bank b word a ← `config_data[15:0]`.
  - Read (`config_read`=1): next cycle `read_data` = {16'b0, word}. If multiple bits are set, the lowest-numbered bank is read.
  - Register read: `config_read`=1 with `config_en`=1 and index 0 returns {16'b0, CFG}.
  - If the same bank is addressed by a datapath write and a config write in the same cycle, the config write wins.

## Timing
- Reset (asynchronous assert, synchronous release): CFG=0, `ptr`=0, `cnt`=0, `data_out`=0, `valid_out`=0, `read_data`=0. Memory contents are undefined.
- Sample latency: 1 cycle from the qualifying write edge to `data_out`/`valid_out`.
- `valid_out` is a one-cycle pulse per qualifying write. It asserts on consecutive cycles for back-to-back writes.
- Config read latency: 1 cycle.
- CFG takes effect the cycle after it is loaded. Changing `depth` while running also requires a `flush`.
- Asserting reset mid-stream drops all pending samples and clears the outputs immediately.

## Test plan
- Depth fill: CFG={depth=10, tile_en=1, mode=0}, `wen_in`=1 every cycle with data 1,2,3,… → `valid_out` stays 0 for the first 10 writes. The cycle after the 11th write gives `data_out`=1, `valid_out`=1, then 2,3,… each cycle.
- Random `wen_in` (50%) with incrementing data, depth 10 → outputs appear only on the cycle after writes once 10 words are stored, and the output sequence is exactly 1,2,3,… with no gaps.
- `flush` held 3 cycles mid-stream while writing → `valid_out`=0 during the flush and for the next 10 writes. The first post-flush output equals the first value written after the flush.
- `clk_en`=0 for 5 cycles while toggling `wen_in`/`flush` → `ptr`, `cnt` and outputs unchanged; after `clk_en` returns to 1 the stream resumes in order.
- SRAM debug: with `clk_en`=0, `config_en_sram`=4'b0001, `config_read`=1, `config_addr`=0x07000000 → `read_data`[15:0] equals the sample stored at linear index 7.
- Depth 1 and depth 0: depth 1 → each write outputs the previous write's value. Depth 0 → `valid_out` never asserts.
